lcd_frame_arbiter: RTL and testbench
====================================

LCD_FRAME_ARBITER -- requirements
Module: lcd_frame_arbiter

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 1024, the number of bytes per frame (8 pages x 64 columns x 2 halves).
REQ-002 SHALL have parameter ADDR_W, default 10, the read-address width, with 2^ADDR_W >= FRAME_BYTES.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports req0 / req1  input  1 each  frame-refresh request from source 0 / source 1, level-sensitive.
REQ-006 SHALL have ports src0_data / src1_data  input  8 each  byte from source 0 / 1 at rd_addr, combinational within the source.
REQ-007 SHALL have port en_tran  input  1  downstream LCD controller ready to accept a byte.
REQ-008 SHALL have ports grant0 / grant1  output  1 each  source 0 / 1 owns the current frame.
REQ-009 SHALL have port rd_addr  output  ADDR_W  byte index presented to the granted source.
REQ-010 SHALL have port data_out  output  8  registered byte to the LCD controller.
REQ-011 SHALL have port data_valid  output  1  data_out holds an untransferred byte.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse when a frame completes.

Function
REQ-013 SHALL implement the states IDLE, FETCH, SEND and DONE.
REQ-014 In IDLE with neither request high, SHALL remain in IDLE with both grants low.
REQ-015 In IDLE with exactly one request high, SHALL assert that grant, set rd_addr=0 and go to FETCH next cycle.
REQ-016 In IDLE with both requests high, SHALL grant the source not recorded in last_grant (round-robin).
REQ-017 last_grant SHALL be updated to the granted index when the grant is issued.
REQ-018 Grants SHALL be one-hot or zero, and a grant SHALL be held from IDLE exit until DONE.
REQ-019 Request deassertion mid-frame SHALL be ignored; the frame SHALL complete.
REQ-020 In FETCH, SHALL register the granted source's data at rd_addr into data_out, set data_valid=1 and go to SEND, giving a latency of one cycle from address to valid.
REQ-021 In SEND, data_out and rd_addr SHALL hold stable while en_tran=0.
REQ-022 A transfer SHALL occur in a cycle with data_valid=1 and en_tran=1.
REQ-023 On a transfer, SHALL clear data_valid next cycle.
REQ-024 On a transfer with rd_addr < FRAME_BYTES-1, SHALL increment rd_addr and go to FETCH.
REQ-025 On a transfer with rd_addr = FRAME_BYTES-1, SHALL go to DONE without incrementing; rd_addr SHALL never wrap.
REQ-026 en_tran SHALL be ignored in IDLE, FETCH and DONE.
REQ-027 Peak throughput SHALL be one byte per 2 cycles.
REQ-028 DONE SHALL last exactly one cycle, with frame_done=1, both grants low and data_valid=0.
REQ-029 After DONE, SHALL return to IDLE; a request still high SHALL be arbitrated in that IDLE cycle, giving at least one idle cycle between frames.
REQ-030 frame_done SHALL be 0 in every state other than DONE.

Reset
REQ-031 When rst=1 at a clock edge, SHALL enter IDLE and set grant0=grant1=0, rd_addr=0, data_out=8'h00, data_valid=0, frame_done=0 and last_grant=1, so source 0 wins the first tie.
REQ-032 Reset SHALL take priority over every other event, including mid-frame and during a transfer cycle, and SHALL not produce a frame_done pulse.

Verification
REQ-033 Bench SHALL cover: req0=1 only, en_tran=1, src0_data=rd_addr[7:0] -> grant0 for 2048 cycles, data_out sequence 00..FF repeating, one frame_done, rd_addr stops at 1023.
REQ-034 Bench SHALL cover: req0=req1=1 held after reset -> frames granted 0,1,0,1; each frame_done followed by the opposite grant two cycles later.
REQ-035 Bench SHALL cover: en_tran=0 for 50 cycles during SEND at rd_addr=5 -> data_out and rd_addr stable, data_valid=1 throughout, advance to 6 after en_tran rises.
REQ-036 Bench SHALL cover: req1 dropped at rd_addr=300 -> grant1 stays high until frame_done at byte 1023.
REQ-037 Bench SHALL cover: rst=1 pulsed at rd_addr=512 during a transfer -> next cycle all outputs 0, no frame_done; with both requests high afterwards, source 0 is granted.
REQ-038 Bench SHALL cover: FRAME_BYTES=4 -> exactly 4 transfers, frame_done on the cycle after the 4th, rd_addr max 3.

Source files
------------

// File: rtl/lcd_frame_arbiter.sv
// lcd_frame_arbiter: round-robin arbiter that streams one whole frame at a time
// from one of two byte sources to an LCD controller, at most one byte every two cycles.
module lcd_frame_arbiter #(
  parameter int FRAME_BYTES = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [7:0]        src0_data,
  input  logic [7:0]        src1_data,
  input  logic              en_tran,
  output logic              grant0,
  output logic              grant1,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        data_out,
  output logic              data_valid,
  output logic              frame_done
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant0_d, grant1_d;
  logic              data_valid_d, frame_done_d;
  logic [ADDR_W-1:0] rd_addr_d;
  logic [7:0]        data_out_d;
  logic [7:0]        src_data;
  logic              pick1;

  assign src_data = grant1 ? src1_data : src0_data;

  // Source 1 wins when it is the only requester, or on a tie when source 0 was served last.
  assign pick1 = req1 & (~req0 | ~last_grant_q);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant0_d     = grant0;
    grant1_d     = grant1;
    rd_addr_d    = rd_addr;
    data_out_d   = data_out;
    data_valid_d = data_valid;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        grant0_d = 1'b0;
        grant1_d = 1'b0;
        if (req0 | req1) begin
          grant0_d     = ~pick1;
          grant1_d     = pick1;
          last_grant_d = pick1;
          rd_addr_d    = '0;
          state_d      = FETCH;
        end
      end

      FETCH: begin
        data_out_d   = src_data;
        data_valid_d = 1'b1;
        state_d      = SEND;
      end

      SEND: begin
        if (en_tran) begin
          data_valid_d = 1'b0;
          // The final byte ends the frame without touching rd_addr, so it never wraps.
          if (rd_addr == LAST_ADDR) begin
            grant0_d     = 1'b0;
            grant1_d     = 1'b0;
            frame_done_d = 1'b1;
            state_d      = DONE;
          end else begin
            rd_addr_d = rd_addr + ADDR_W'(1);
            state_d   = FETCH;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant0       <= 1'b0;
      grant1       <= 1'b0;
      rd_addr      <= '0;
      data_out     <= 8'h00;
      data_valid   <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant0       <= grant0_d;
      grant1       <= grant1_d;
      rd_addr      <= rd_addr_d;
      data_out     <= data_out_d;
      data_valid   <= data_valid_d;
      frame_done   <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// Self-checking bench for lcd_frame_arbiter: a full-size instance for long frame
// sequences and a 4-byte-frame instance for vector tables and randomized traffic.
module tb_lcd_frame_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Full-size instance (1024-byte frames)
  logic       rst, req0, req1, en_tran;
  logic [7:0] src0_data, src1_data;
  logic       grant0, grant1, data_valid, frame_done;
  logic [9:0] rd_addr;
  logic [7:0] data_out;

  assign src0_data = rd_addr[7:0];
  assign src1_data = ~rd_addr[7:0];

  lcd_frame_arbiter #(.FRAME_BYTES(1024), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .src0_data(src0_data), .src1_data(src1_data), .en_tran(en_tran),
    .grant0(grant0), .grant1(grant1), .rd_addr(rd_addr), .data_out(data_out),
    .data_valid(data_valid), .frame_done(frame_done)
  );

  // Small instance (4-byte frames)
  logic       s_rst, s_req0, s_req1, s_en_tran;
  logic [7:0] s_src0_data, s_src1_data;
  logic       s_grant0, s_grant1, s_data_valid, s_frame_done;
  logic [1:0] s_rd_addr;
  logic [7:0] s_data_out;

  assign s_src0_data = 8'hA0 + {6'd0, s_rd_addr};
  assign s_src1_data = 8'hB0 + {6'd0, s_rd_addr};

  lcd_frame_arbiter #(.FRAME_BYTES(4), .ADDR_W(2)) dut_small (
    .clk(clk), .rst(s_rst), .req0(s_req0), .req1(s_req1),
    .src0_data(s_src0_data), .src1_data(s_src1_data), .en_tran(s_en_tran),
    .grant0(s_grant0), .grant1(s_grant1), .rd_addr(s_rd_addr), .data_out(s_data_out),
    .data_valid(s_data_valid), .frame_done(s_frame_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; en_tran = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_fd(input string name);
    int n;
    n = 0;
    while (!frame_done && n < 3000) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, 32'(frame_done), 32'd1);
  endtask

  // Expected byte of a frame owned by source 'own' at byte index k (small instance)
  function automatic logic [7:0] src_byte(input int own, input int k);
    return (own == 1) ? (8'hB0 + 8'(k)) : (8'hA0 + 8'(k));
  endfunction

  function automatic logic [1:0] grant_bits(input int own);
    return (own == 0) ? 2'b10 : (own == 1) ? 2'b01 : 2'b00;
  endfunction

  typedef struct {
    logic       r0, r1, en;
    logic       g0, g1;
    logic [1:0] addr;
    logic       dv, fd;
    logic [7:0] dout;
  } vec_t;

  function automatic vec_t mk(input logic r0, input logic r1, input logic en,
                              input logic g0, input logic g1, input logic [1:0] addr,
                              input logic dv, input logic fd, input logic [7:0] dout);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.en = en; v.g0 = g0; v.g1 = g1;
    v.addr = addr; v.dv = dv; v.fd = fd; v.dout = dout;
    return v;
  endfunction

  vec_t vecs[$];

  int         n, n_xfer, n_fd, bad, low, owner, last_owner, nbytes, frames, want;
  logic [9:0] max_addr, hold_a;
  logic [7:0] hold_d;
  logic       p_r0, p_r1, p_en, p_g0, p_g1, p_dv, p_fd;
  logic [7:0] p_dout;
  logic [1:0] p_addr;

  initial begin
    s_rst = 1'b1; s_req0 = 1'b0; s_req1 = 1'b0; s_en_tran = 1'b0;

    // Reset state
    do_reset();
    check("reset_grants", 32'({grant0, grant1}), 32'd0);
    check("reset_addr", 32'(rd_addr), 32'd0);
    check("reset_data", 32'({data_out, data_valid, frame_done}), 32'd0);

    // Single requester streams bytes 00..FF repeating, one frame_done, rd_addr tops at 1023
    do_reset();
    req0 = 1'b1; en_tran = 1'b1;
    n_xfer = 0; n_fd = 0; bad = 0; max_addr = '0;
    for (int c = 0; c < 2060; c++) begin
      if (data_valid && en_tran) begin
        if (data_out !== 8'(n_xfer % 256)) bad++;
        n_xfer++;
      end
      if (rd_addr > max_addr) max_addr = rd_addr;
      if (frame_done) begin
        n_fd++;
        if (n_fd == 1) begin
          check("stream_done_addr", 32'(rd_addr), 32'd1023);
          check("stream_done_count", 32'(n_xfer), 32'd1024);
        end
      end
      if (c > 0 && c < 2049) if (!grant0 || grant1) bad++;
      tick();
    end
    check("stream_bytes_bad", 32'(bad), 32'd0);
    check("stream_frame_done_count", 32'(n_fd), 32'd1);
    check("stream_max_addr", 32'(max_addr), 32'd1023);

    // Both requesting: frames alternate 0,1,0,1; opposite grant two cycles after frame_done
    do_reset();
    req0 = 1'b1; req1 = 1'b1; en_tran = 1'b1;
    tick();
    owner = 0;
    for (int f = 0; f < 4; f++) begin
      check($sformatf("rr_grant_%0d", f), 32'({grant0, grant1}), 32'(grant_bits(owner)));
      wait_fd($sformatf("rr_fd_%0d", f));
      check($sformatf("rr_done_grants_%0d", f), 32'({grant0, grant1}), 32'd0);
      tick();
      check($sformatf("rr_idle_%0d", f), 32'({grant0, grant1, frame_done}), 32'd0);
      tick();
      owner = 1 - owner;
    end

    // Stall at rd_addr 5 for 50 cycles
    do_reset();
    req0 = 1'b1; en_tran = 1'b1;
    n = 0;
    while (!(data_valid && rd_addr == 10'd5) && n < 100) begin
      tick();
      n++;
    end
    check("stall_reached", 32'({data_valid, rd_addr}), 32'({1'b1, 10'd5}));
    en_tran = 1'b0;
    hold_d = data_out; hold_a = rd_addr; bad = 0;
    check("stall_byte", 32'(hold_d), 32'h05);
    for (int c = 0; c < 50; c++) begin
      tick();
      if ({data_valid, data_out, rd_addr} !== {1'b1, hold_d, hold_a}) bad++;
    end
    check("stall_stable", 32'(bad), 32'd0);
    en_tran = 1'b1;
    tick();
    check("stall_advance", 32'({rd_addr, data_valid}), 32'({10'd6, 1'b0}));
    tick();
    check("stall_next_byte", 32'({data_valid, data_out}), 32'({1'b1, 8'h06}));

    // Request drop mid-frame is ignored
    do_reset();
    req1 = 1'b1; en_tran = 1'b1;
    n = 0;
    while (rd_addr != 10'd300 && n < 1000) begin
      tick();
      n++;
    end
    check("drop_reached", 32'(rd_addr), 32'd300);
    req1 = 1'b0; low = 0; n = 0;
    while (!frame_done && n < 3000) begin
      if (!grant1) low++;
      tick();
      n++;
    end
    check("drop_frame_done", 32'(frame_done), 32'd1);
    check("drop_grant_held", 32'(low), 32'd0);
    check("drop_final_addr", 32'(rd_addr), 32'd1023);
    tick();
    tick();
    check("drop_no_regrant", 32'({grant0, grant1}), 32'd0);

    // Reset during a transfer at rd_addr 512, then a tie goes to source 0
    do_reset();
    req0 = 1'b1; en_tran = 1'b1;
    n = 0;
    while (!(data_valid && rd_addr == 10'd512) && n < 1500) begin
      tick();
      n++;
    end
    check("rst_reached", 32'({data_valid, rd_addr}), 32'({1'b1, 10'd512}));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_outputs", 32'({grant0, grant1, data_valid, data_out, rd_addr}), 32'd0);
    check("rst_no_frame_done", 32'(frame_done), 32'd0);
    req0 = 1'b1; req1 = 1'b1;
    tick();
    check("rst_tie_to_src0", 32'({grant0, grant1}), 32'b10);
    req0 = 1'b0; req1 = 1'b0; en_tran = 1'b0;

    // Vector table on the 4-byte instance
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 8'hA0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 8'hA0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 8'hA0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 8'hA1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 8'hA1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 8'hA2));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 8'hA2));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 8'hA3));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 8'hA3));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 8'hA3));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 8'hA3));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 8'hB0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'hB0));

    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    foreach (vecs[i]) begin
      s_req0 = vecs[i].r0; s_req1 = vecs[i].r1; s_en_tran = vecs[i].en;
      tick();
      check($sformatf("vec_%0d", i),
            32'({s_grant0, s_grant1, s_rd_addr, s_data_valid, s_frame_done, s_data_out}),
            32'({vecs[i].g0, vecs[i].g1, vecs[i].addr, vecs[i].dv, vecs[i].fd, vecs[i].dout}));
    end

    // Randomized traffic on the 4-byte instance against a transaction-level model
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    last_owner = 1; owner = -1; nbytes = 0; frames = 0;
    for (int c = 0; c < 3000; c++) begin
      s_req0 = ($urandom_range(0, 1) == 1);
      s_req1 = ($urandom_range(0, 1) == 1);
      s_en_tran = ($urandom_range(0, 2) != 0);
      p_r0 = s_req0; p_r1 = s_req1; p_en = s_en_tran;
      p_g0 = s_grant0; p_g1 = s_grant1; p_dv = s_data_valid; p_fd = s_frame_done;
      p_dout = s_data_out; p_addr = s_rd_addr;
      tick();
      check("rand_onehot", 32'(s_grant0 & s_grant1), 32'd0);
      if (p_fd) begin
        check("rand_after_done", 32'({s_grant0, s_grant1, s_frame_done, s_data_valid}), 32'd0);
      end else if (!p_g0 && !p_g1) begin
        want = -1;
        if (p_r0 && p_r1) want = 1 - last_owner;
        else if (p_r0)    want = 0;
        else if (p_r1)    want = 1;
        check("rand_arbitrate", 32'({s_grant0, s_grant1}), 32'(grant_bits(want)));
        if (want >= 0) begin
          owner = want; last_owner = want; nbytes = 0; frames++;
          check("rand_start_addr", 32'(s_rd_addr), 32'd0);
        end
      end else if (p_dv && p_en) begin
        check("rand_xfer_addr", 32'(p_addr), 32'(nbytes));
        check("rand_xfer_data", 32'(p_dout), 32'(src_byte(owner, nbytes)));
        nbytes++;
        if (nbytes == 4) begin
          check("rand_done", 32'({s_grant0, s_grant1, s_frame_done, s_data_valid}), 32'b0010);
          owner = -1;
        end else begin
          check("rand_next",
                32'({s_grant0, s_grant1, s_frame_done, s_data_valid, s_rd_addr}),
                32'({grant_bits(owner), 2'b00, nbytes[1:0]}));
        end
      end else if (p_dv) begin
        check("rand_stall",
              32'({s_data_valid, s_data_out, s_rd_addr, s_grant0, s_grant1, s_frame_done}),
              32'({1'b1, p_dout, p_addr, p_g0, p_g1, 1'b0}));
      end else begin
        check("rand_fetch",
              32'({s_grant0, s_grant1, s_frame_done, s_data_valid, s_data_out, s_rd_addr}),
              32'({grant_bits(owner), 1'b0, 1'b1, src_byte(owner, nbytes), nbytes[1:0]}));
      end
    end
    check("rand_frames_seen", 32'(frames > 10), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
